// File: rtl/friscv_sv_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package friscv_sv_pkg;

    localparam int ARCH            = 32;
    localparam int IMEM_ARB_WAIT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2
    } imem_owner_t;

endpackage

// File: rtl/imem_arb_prio.sv
// Fixed-priority grant (fetch first) with a starvation counter that forces a debug grant.
// Combinational grant, wait counter registered; optional forced-grant strobe under FRISCV_IMEM_ARB_STATS_EN.
module imem_arb_prio
    import friscv_sv_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic f_req,
    input  logic d_req,
    output logic f_gnt,
    output logic d_gnt
`ifdef FRISCV_IMEM_ARB_STATS_EN
    ,
    output logic forced
`endif
);

    localparam logic [IMEM_ARB_WAIT_W-1:0] WAIT_LIM = IMEM_ARB_WAIT_W'(MAX_WAIT);

    logic [IMEM_ARB_WAIT_W-1:0] wait_cnt;
    logic                       starved;

    assign starved = (wait_cnt == WAIT_LIM);

    always_comb begin
        d_gnt = 1'b0;
        f_gnt = 1'b0;
        if (!rst) begin
            d_gnt = d_req && (!f_req || starved);
            f_gnt = f_req && !d_gnt;
        end
    end

`ifdef FRISCV_IMEM_ARB_STATS_EN
    // A debug grant while fetch is also asking can only come from starvation.
    assign forced = d_gnt && f_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!d_req || d_gnt) begin
            wait_cnt <= '0;
        end else if (!starved) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares instr_mem between fetch (F) and debug (D); F priority with forced D grant after MAX_WAIT denials.
// Latency: grant and memory address in cycle N, rvalid/rdata in N+1; stats ports exist only with FRISCV_IMEM_ARB_STATS_EN.
// Backpressure: requesters hold req/addr until gnt; responses cannot be stalled.
module imem_arbiter
    import friscv_sv_pkg::*;
#(
    parameter int RAM_DEPTH = 4096,
    parameter int RAM_WIDTH = ARCH,
    parameter int MAX_WAIT  = 4,
    localparam int AW       = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_req_in,
    input  logic [AW-1:0]        f_addr_in,
    output logic                 f_gnt_out,
    output logic                 f_rvalid_out,
    output logic                 f_rerr_out,
    input  logic                 d_req_in,
    input  logic [AW-1:0]        d_addr_in,
    output logic                 d_gnt_out,
    output logic                 d_rvalid_out,
    output logic                 d_rerr_out,
    output logic [RAM_WIDTH-1:0] rdata_out,
    output logic [AW-1:0]        mem_addr_out,
    input  logic [RAM_WIDTH-1:0] mem_data_in
`ifdef FRISCV_IMEM_ARB_STATS_EN
    ,
    output logic [31:0]          f_gnt_cnt_out,
    output logic [31:0]          d_gnt_cnt_out,
    output logic [15:0]          forced_cnt_out
`endif
);

    logic          f_gnt;
    logic          d_gnt;
    logic          gnt_any;
    logic [AW-1:0] gnt_addr;
    logic          gnt_mis;
    logic          addr_upd;
    imem_owner_t   owner_q;
    logic          err_q;
    logic [AW-1:0] addr_q;

`ifdef FRISCV_IMEM_ARB_STATS_EN
    logic forced;
`endif

    imem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk    (clk),
        .rst    (rst),
        .f_req  (f_req_in),
        .d_req  (d_req_in),
        .f_gnt  (f_gnt),
        .d_gnt  (d_gnt)
`ifdef FRISCV_IMEM_ARB_STATS_EN
        ,
        .forced (forced)
`endif
    );

    assign gnt_any  = f_gnt || d_gnt;
    assign gnt_addr = d_gnt ? d_addr_in : f_addr_in;
    assign gnt_mis  = |gnt_addr[1:0];
    assign addr_upd = gnt_any && !gnt_mis;

    assign f_gnt_out = f_gnt;
    assign d_gnt_out = d_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            owner_q <= d_gnt ? OWN_D : (f_gnt ? OWN_F : OWN_NONE);
            err_q   <= gnt_any && gnt_mis;
            if (addr_upd) begin
                addr_q <= gnt_addr;
            end
        end
    end

    // Outputs are forced quiet during reset so a response in flight is dropped.
    always_comb begin
        mem_addr_out = '0;
        f_rvalid_out = 1'b0;
        d_rvalid_out = 1'b0;
        rdata_out    = '0;
        if (!rst) begin
            mem_addr_out = addr_upd ? gnt_addr : addr_q;
            f_rvalid_out = (owner_q == OWN_F);
            d_rvalid_out = (owner_q == OWN_D);
            if (owner_q != OWN_NONE && !err_q) begin
                rdata_out = mem_data_in;
            end
        end
    end

    assign f_rerr_out = f_rvalid_out && err_q;
    assign d_rerr_out = d_rvalid_out && err_q;

`ifdef FRISCV_IMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            f_gnt_cnt_out  <= '0;
            d_gnt_cnt_out  <= '0;
            forced_cnt_out <= '0;
        end else begin
            if (f_gnt) f_gnt_cnt_out <= f_gnt_cnt_out + 32'd1;
            if (d_gnt) d_gnt_cnt_out <= d_gnt_cnt_out + 32'd1;
            if (forced && forced_cnt_out != 16'hFFFF) begin
                forced_cnt_out <= forced_cnt_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed requests push expected responses, a monitor pops on rvalid.
module tb_imem_arbiter;

    localparam int AW = 12;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_rvalid, f_rerr;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_gnt, d_rvalid, d_rerr;
    logic [W-1:0]  rdata;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_data = '0;
`ifdef FRISCV_IMEM_ARB_STATS_EN
    logic [31:0]   f_gnt_cnt, d_gnt_cnt;
    logic [15:0]   forced_cnt;
`endif

    imem_arbiter #(
        .RAM_DEPTH (4096),
        .RAM_WIDTH (W),
        .MAX_WAIT  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .f_req_in     (f_req),
        .f_addr_in    (f_addr),
        .f_gnt_out    (f_gnt),
        .f_rvalid_out (f_rvalid),
        .f_rerr_out   (f_rerr),
        .d_req_in     (d_req),
        .d_addr_in    (d_addr),
        .d_gnt_out    (d_gnt),
        .d_rvalid_out (d_rvalid),
        .d_rerr_out   (d_rerr),
        .rdata_out    (rdata),
        .mem_addr_out (mem_addr),
        .mem_data_in  (mem_data)
`ifdef FRISCV_IMEM_ARB_STATS_EN
        ,
        .f_gnt_cnt_out  (f_gnt_cnt),
        .d_gnt_cnt_out  (d_gnt_cnt),
        .forced_cnt_out (forced_cnt)
`endif
    );

    always #5 clk = ~clk;

    // instr_mem stand-in: word i holds i, one-cycle read latency
    always @(posedge clk) mem_data <= 32'(mem_addr >> 2);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        is_d;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t          sb[$];
    int            n_pass = 0;
    int            n_total = 0;
    logic [AW-1:0] exp_addr = '0;
    int            exp_fcnt = 0;
    int            exp_dcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every rvalid must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (f_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                chk("spurious_rvalid", {f_rvalid, d_rvalid}, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("f_rvalid", f_rvalid, !e.is_d);
                chk("d_rvalid", d_rvalid, e.is_d);
                chk("f_rerr", f_rerr, !e.is_d && e.err);
                chk("d_rerr", d_rerr, e.is_d && e.err);
                chk("rdata", rdata, e.data);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("rvalid_missing", 0, 1);
        end
    end

    task automatic step(input logic fr, input logic [AW-1:0] fa, input logic dr,
                        input logic [AW-1:0] da, input logic efg, input logic edg,
                        input logic push);
        logic [AW-1:0] ga;
        logic          mis;
        exp_t          e;
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        @(negedge clk);
        chk("f_gnt", f_gnt, efg);
        chk("d_gnt", d_gnt, edg);
        ga  = edg ? da : fa;
        mis = |ga[1:0];
        if ((efg || edg) && !mis) exp_addr = ga;
        chk("mem_addr", mem_addr, exp_addr);
        if (efg) exp_fcnt++;
        if (edg) exp_dcnt++;
        if ((efg || edg) && push) begin
            e.cyc  = cyc + 1;
            e.is_d = edg;
            e.err  = mis;
            e.data = mis ? 32'd0 : 32'(ga >> 2);
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, {f_gnt, d_gnt}, 0);
        chk({tag, "_rvalid"}, {f_rvalid, d_rvalid}, 0);
        chk({tag, "_rerr"}, {f_rerr, d_rerr}, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
    endtask

    initial begin
        rst = 1'b1; f_req = 1'b1; f_addr = 12'h044; d_req = 1'b1; d_addr = 12'h048;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // fetch stream 0,4,8
        step(1, 12'h000, 0, 12'h000, 1, 0, 1);
        step(1, 12'h004, 0, 12'h000, 1, 0, 1);
        step(1, 12'h008, 0, 12'h000, 1, 0, 1);
        step(0, 12'h000, 0, 12'h000, 0, 0, 1);
        // debug alone, then misaligned fetch and debug
        step(0, 12'h000, 1, 12'h100, 0, 1, 1);
        step(1, 12'h006, 0, 12'h000, 1, 0, 1);
        step(0, 12'h000, 1, 12'h102, 0, 1, 1);
        step(0, 12'h000, 0, 12'h000, 0, 0, 1);
        // contention: F wins four, D forced on the fifth, repeating
        for (int i = 0; i < 10; i++)
            step(1, 12'h010, 1, 12'h200, (i % 5) != 4, (i % 5) == 4, 1);
        // alternating owners with no bubble
        step(1, 12'h020, 0, 12'h000, 1, 0, 1);
        step(0, 12'h000, 1, 12'h024, 0, 1, 1);
        step(1, 12'h028, 0, 12'h000, 1, 0, 1);
        step(0, 12'h000, 0, 12'h000, 0, 0, 1);

`ifdef FRISCV_IMEM_ARB_STATS_EN
        chk("f_gnt_cnt", f_gnt_cnt, 32'(exp_fcnt));
        chk("d_gnt_cnt", d_gnt_cnt, 32'(exp_dcnt));
        chk("forced_cnt", 32'(forced_cnt), 32'd2);
`endif

        // reset right after a debug grant drops its response
        step(0, 12'h000, 1, 12'h300, 0, 1, 0);
        rst = 1'b1; f_req = 1'b1; f_addr = 12'h050; d_req = 1'b1; d_addr = 12'h054;
        @(negedge clk);
        chk_quiet("rst_pending");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_addr = '0; exp_fcnt = 0; exp_dcnt = 0;
`ifdef FRISCV_IMEM_ARB_STATS_EN
        chk("f_gnt_cnt_rst", f_gnt_cnt, 32'd0);
        chk("forced_cnt_rst", 32'(forced_cnt), 32'd0);
`endif
        step(1, 12'h040, 0, 12'h000, 1, 0, 1);
        step(0, 12'h000, 0, 12'h000, 0, 0, 1);
        step(0, 12'h000, 0, 12'h000, 0, 0, 1);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
